// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI-Stream output among NUM_SRC sources.
// A grant is held from arbitration until the tlast beat, so packets never interleave.
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [15:0]               pkt_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q;
  logic               grant_valid_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [15:0]        pkt_cnt_q;
  logic [15:0]        pkt_cnt_d;

  logic [DATA_W-1:0]  src_data [NUM_SRC];
  logic [IDX_W-1:0]   cand_idx [NUM_SRC];
  logic [IDX_W-1:0]   sel_idx_d;
  logic               sel_found_d;
  logic               beat_fire;
  logic               pkt_done;

  if (NUM_SRC < 2 || NUM_SRC > 8 || IDX_W != $clog2(NUM_SRC)) begin : g_bad_param
    $error("axis_rr_arbiter: NUM_SRC must be 2..8 and IDX_W must equal clog2(NUM_SRC)");
  end

  // cand_idx[k] is the k-th source in priority order, starting just after the last winner.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_data[gi] = s_tdata[gi*DATA_W +: DATA_W];
    assign cand_idx[gi] = IDX_W'((int'(last_grant_q) + gi + 1) % NUM_SRC);
  end

  always_comb begin
    sel_found_d = 1'b0;
    sel_idx_d   = last_grant_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!sel_found_d && s_tvalid[cand_idx[k]]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = cand_idx[k];
      end
    end
  end

  // Pure combinational pass-through of the granted source while in GRANT.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == ST_GRANT) begin
      m_tvalid              = s_tvalid[grant_idx_q];
      m_tdata               = src_data[grant_idx_q];
      m_tlast               = s_tlast[grant_idx_q];
      s_tready[grant_idx_q] = m_tready;
    end
  end

  assign beat_fire = m_tvalid && m_tready;
  assign pkt_done  = beat_fire && m_tlast;
  assign pkt_cnt_d = pkt_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_grant_q  <= IDX_W'(NUM_SRC - 1);
      pkt_cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found_d) begin
            grant_idx_q   <= sel_idx_d;
            grant_valid_q <= 1'b1;
            state_q       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (pkt_done) begin
            last_grant_q  <= grant_idx_q;
            pkt_cnt_q     <= pkt_cnt_d;
            grant_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: queued source models feed the DUT, a negedge monitor
// pops expected beats and compares them; status/reset checks are requested through flags.
module tb_axis_rr_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      resetn;
  logic [NUM_SRC-1:0]        s_tvalid;
  logic [NUM_SRC*DATA_W-1:0] s_tdata;
  logic [NUM_SRC-1:0]        s_tlast;
  logic [NUM_SRC-1:0]        s_tready;
  logic                      m_tvalid;
  logic [DATA_W-1:0]         m_tdata;
  logic                      m_tlast;
  logic                      m_tready;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_idx;
  logic [15:0]               pkt_cnt;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                src;
    bit                gap;
  } beat_t;

  beat_t             exp_q [$];
  logic [DATA_W:0]   src_q [NUM_SRC][$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int last_tlast_cyc = 0;
  int beats_total = 0;
  logic [NUM_SRC-1:0] fire_s = '0;

  bit          chk_rst  = 1'b0;
  bit          chk_gnt  = 1'b0;
  bit          chk_stat = 1'b0;
  int          exp_gidx = 0;
  int          exp_cnt  = 0;
  bit          bp_mode  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total_cnt++;
    if (act !== req)
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    else
      pass_cnt++;
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    logic [NUM_SRC-1:0] rdy_exp;
    cyc++;
    fire_s = s_tvalid & s_tready;
    if (resetn) begin
      rdy_exp = '0;
      if (grant_valid) rdy_exp[grant_idx] = m_tready;
      check("s_tready_pattern", 32'(s_tready), 32'(rdy_exp));
      if (!grant_valid) check("idle_m_tvalid", 32'(m_tvalid), 32'd0);
      if (m_tvalid && m_tready) begin
        beats_total++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: got data 0x%0h from src %0d, required no beat", m_tdata, grant_idx);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", 32'(m_tdata), 32'(b.data));
          check("beat_last", 32'(m_tlast), 32'(b.last));
          check("beat_src", 32'(grant_idx), 32'(b.src));
          if (b.gap) check("bubble_cycles", 32'(cyc - last_tlast_cyc), 32'd2);
          $display("beat src=%0d data=0x%0h last=%0b pkt_cnt=%0d", grant_idx, m_tdata, m_tlast, pkt_cnt);
        end
        if (m_tlast) last_tlast_cyc = cyc;
      end
    end
    if (chk_rst) begin
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check("rst_grant_valid", 32'(grant_valid), 32'd0);
      check("rst_grant_idx", 32'(grant_idx), 32'd0);
      check("rst_m_tdata", 32'(m_tdata), 32'd0);
      check("rst_m_tlast", 32'(m_tlast), 32'd0);
    end
    if (chk_gnt) begin
      check("gnt_valid", 32'(grant_valid), 32'd1);
      check("gnt_idx", 32'(grant_idx), 32'(exp_gidx));
    end
    if (chk_stat) begin
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
      check("idle_after_pkt", 32'(grant_valid), 32'd0);
      $display("status pkt_cnt=%0d grant_valid=%0b", pkt_cnt, grant_valid);
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]                   = 1'b1;
        s_tdata[i*DATA_W +: DATA_W]   = src_q[i][0][DATA_W-1:0];
        s_tlast[i]                    = src_q[i][0][DATA_W];
      end else begin
        s_tvalid[i]                   = 1'b0;
        s_tdata[i*DATA_W +: DATA_W]   = '0;
        s_tlast[i]                    = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++)
      if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (bp_mode) m_tready = ~m_tready;
    drive();
  endtask

  task automatic load_pkt(input int src, input int base, input int n);
    for (int j = 0; j < n; j++) src_q[src].push_back({(j == n - 1), DATA_W'(base + j)});
    drive();
  endtask

  task automatic expect_pkt(input int src, input int base, input int n, input bit gap);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data = DATA_W'(base + j);
      b.last = (j == n - 1);
      b.src  = src;
      b.gap  = gap && (j == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    repeat (2) tick();
  endtask

  task automatic status(input int cnt);
    exp_cnt  = cnt;
    chk_stat = 1'b1;
    @(negedge clk); #1;
    chk_stat = 1'b0;
  endtask

  task automatic reset_check();
    chk_rst = 1'b1;
    @(negedge clk); #1;
    chk_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int n;
    resetn   = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;

    // Reset with every source requesting, then round-robin over 2-beat packets.
    load_pkt(0, 16'h100, 2); load_pkt(0, 16'h104, 2);
    load_pkt(1, 16'h110, 2); load_pkt(1, 16'h114, 2);
    load_pkt(2, 16'h120, 2);
    load_pkt(3, 16'h130, 2);
    repeat (3) tick();
    reset_check();
    tick();
    resetn = 1'b1;
    expect_pkt(0, 16'h100, 2, 1'b0);
    expect_pkt(1, 16'h110, 2, 1'b1);
    expect_pkt(2, 16'h120, 2, 1'b1);
    expect_pkt(3, 16'h130, 2, 1'b1);
    expect_pkt(0, 16'h104, 2, 1'b1);
    expect_pkt(1, 16'h114, 2, 1'b1);
    tick();
    exp_gidx = 0;
    chk_gnt  = 1'b1;
    @(negedge clk); #1;
    chk_gnt  = 1'b0;
    wait_drain();
    status(6);

    // Fresh reset, then a single 9-beat packet from source 1.
    tick(); resetn = 1'b0;
    tick(); resetn = 1'b1;
    load_pkt(1, 800, 9);
    expect_pkt(1, 800, 9, 1'b0);
    wait_drain();
    status(1);

    // Backpressure on source 2 while source 3 also waits.
    bp_mode = 1'b1;
    load_pkt(2, 16'h200, 6);
    load_pkt(3, 16'h300, 2);
    expect_pkt(2, 16'h200, 6, 1'b0);
    expect_pkt(3, 16'h300, 2, 1'b0);
    wait_drain();
    bp_mode  = 1'b0;
    m_tready = 1'b1;
    status(3);

    // Source 3 just finished: simultaneous requests from 3 and 0 must go to 0 first.
    load_pkt(3, 16'h310, 2);
    load_pkt(0, 16'h400, 2);
    expect_pkt(0, 16'h400, 2, 1'b0);
    expect_pkt(3, 16'h310, 2, 1'b1);
    wait_drain();
    status(5);

    // Source 0 wins a single-beat packet, then source 2 is cut off by reset on beat 4.
    load_pkt(0, 16'h500, 1);
    expect_pkt(0, 16'h500, 1, 1'b0);
    wait_drain();
    status(6);
    start = beats_total;
    load_pkt(2, 16'h900, 9);
    expect_pkt(2, 16'h900, 3, 1'b0);
    exp_q[$].last = 1'b0;
    n = 0;
    while (beats_total - start < 3 && n < 200) begin
      tick();
      n++;
    end
    #1;
    resetn = 1'b0;
    reset_check();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    drive();
    tick();
    resetn = 1'b1;
    load_pkt(1, 16'h600, 2);
    load_pkt(0, 16'h610, 2);
    expect_pkt(0, 16'h610, 2, 1'b0);
    expect_pkt(1, 16'h600, 2, 1'b1);
    wait_drain();
    status(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
